// File: rtl/ic_tag_wr_pkg.sv
// ic_tag_wr_pkg
//   Shared types and constants for the I-cache tag-RAM write path.
//   TAG_W/IDX_W/ECC_W : tag payload, tag RAM index and check-bit widths
//   tag_wr_req_t      : one buffered tag-write request {idx, tag}
//   wr_state_e        : write-pipe controller states
//   INVAL_TAG         : tag value written by the flash-invalidate sweep
package ic_tag_wr_pkg;

  localparam int unsigned TAG_W = 21;
  localparam int unsigned IDX_W = 8;
  localparam int unsigned ECC_W = 7;

  typedef struct packed {
    logic [IDX_W-1:0] idx;
    logic [TAG_W-1:0] tag;
  } tag_wr_req_t;

  typedef enum logic [1:0] {
    IDLE,
    DRAIN,
    SWEEP
  } wr_state_e;

  localparam logic [TAG_W-1:0] INVAL_TAG = '0;

endpackage

// File: rtl/ic_tag_wr_pipe_if.sv
// ic_tag_wr_pipe_if
//   Valid/ready tag-write request bus.
//   wr_valid : request valid (master -> slave)
//   wr_ready : request accepted when wr_valid & wr_ready (slave -> master)
//   wr_idx   : target tag RAM index
//   wr_tag   : tag payload
interface ic_tag_wr_pipe_if #(
  parameter int unsigned TAG_W = ic_tag_wr_pkg::TAG_W,
  parameter int unsigned IDX_W = ic_tag_wr_pkg::IDX_W
);

  logic             wr_valid;
  logic             wr_ready;
  logic [IDX_W-1:0] wr_idx;
  logic [TAG_W-1:0] wr_tag;

  modport master (
    output wr_valid,
    output wr_idx,
    output wr_tag,
    input  wr_ready
  );

  modport slave (
    input  wr_valid,
    input  wr_idx,
    input  wr_tag,
    output wr_ready
  );

endinterface

// File: rtl/ic_tag_ecc_encoder.sv
// ic_tag_ecc_encoder
//   Combinational 7-bit check-bit generator for one tag RAM word.
//   The protected data word is {idx, tag}, so the index is covered too.
//     ecc[4:0] : Hamming checks; bit j is the XOR of every data bit whose
//                1-based position has bit j set
//     ecc[5]   : parity of idx
//     ecc[6]   : inverted parity of tag, so an all-zero tag never yields an
//                all-zero check field
//   Ports: idx (in, IDX_W), tag (in, TAG_W), ecc (out, ECC_W)
module ic_tag_ecc_encoder
  import ic_tag_wr_pkg::*;
(
  input  logic [IDX_W-1:0] idx,
  input  logic [TAG_W-1:0] tag,
  output logic [ECC_W-1:0] ecc
);

  localparam int unsigned DATA_W = IDX_W + TAG_W;

  logic [DATA_W-1:0] data;

  assign data = {idx, tag};

  always_comb begin
    ecc = '0;
    for (int unsigned j = 0; j < 5; j++) begin
      for (int unsigned i = 0; i < DATA_W; i++) begin
        if ((((i + 1) >> j) & 32'd1) != 32'd0) begin
          ecc[j] = ecc[j] ^ data[i];
        end
      end
    end
    ecc[5] = ^idx;
    ecc[6] = ~(^tag);
  end

endmodule

// File: rtl/ic_tag_wr_fifo.sv
// ic_tag_wr_fifo
//   DEPTH-entry FIFO of tag_wr_req_t. Head is visible combinationally;
//   push and pop may happen in the same cycle. Callers never push when full
//   or pop when empty.
//   Ports: clk, rst_a (async, active-low), push/push_data, pop,
//          head (oldest entry), full, empty
module ic_tag_wr_fifo
  import ic_tag_wr_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_a,
  input  logic        push,
  input  tag_wr_req_t push_data,
  input  logic        pop,
  output tag_wr_req_t head,
  output logic        full,
  output logic        empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  tag_wr_req_t      mem [DEPTH];
  // Pointers carry one extra wrap bit to tell full from empty.
  logic [PTR_W:0]   wptr;
  logic [PTR_W:0]   rptr;

  always_ff @(posedge clk or negedge rst_a) begin
    if (!rst_a) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wptr[PTR_W-1:0]] <= push_data;
  end

  assign head  = mem[rptr[PTR_W-1:0]];
  assign empty = (wptr == rptr);
  assign full  = (wptr[PTR_W] != rptr[PTR_W]) &&
                 (wptr[PTR_W-1:0] == rptr[PTR_W-1:0]);

endmodule

// File: rtl/ic_tag_wr_pipe.sv
// ic_tag_wr_pipe
//   Write-side front end of the I-cache tag RAM. Buffers tag-write requests,
//   adds ECC, and issues at most one registered RAM write per cycle when the
//   read port is idle. Also runs the full-array flash-invalidate sweep.
//   RAM word layout is {ecc, tag}.
//   Optional feature macro: IC_TAG_ECC_ERR_INJ_EN (one-shot ECC error injection).
//   Ports:
//     clk, rst_a        : clock, asynchronous active-low reset
//     wr_if (slave)     : wr_valid/wr_ready/wr_idx/wr_tag request bus
//     rd_active         : tag RAM read this cycle (reads beat writes)
//     inval_req         : pulse, invalidate every index
//     inval_done        : pulse, sweep finished
//     busy              : buffer non-empty, sweep/drain in progress, or inval pending
//     ram_we/ram_addr/ram_wdata : registered tag RAM write port
//     err_inj_arm/err_inj_mask  : arm a one-shot XOR into the next word's ecc
module ic_tag_wr_pipe #(
  parameter int unsigned TAG_W = ic_tag_wr_pkg::TAG_W,
  parameter int unsigned IDX_W = ic_tag_wr_pkg::IDX_W,
  parameter int unsigned ECC_W = ic_tag_wr_pkg::ECC_W,
  parameter int unsigned DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst_a,
  ic_tag_wr_pipe_if.slave        wr_if,
  input  logic                   rd_active,
  input  logic                   inval_req,
  output logic                   inval_done,
  output logic                   busy,
  output logic                   ram_we,
  output logic [IDX_W-1:0]       ram_addr,
  output logic [ECC_W+TAG_W-1:0] ram_wdata,
  input  logic                   err_inj_arm,
  input  logic [ECC_W-1:0]       err_inj_mask
);

  import ic_tag_wr_pkg::*;

  wr_state_e        state;
  logic [IDX_W-1:0] cnt;
  logic             ready_en;

  tag_wr_req_t      head;
  tag_wr_req_t      push_req;
  logic             fifo_full;
  logic             fifo_empty;
  logic             push;
  logic             pop;
  logic             sweep_issue;
  logic             issue;
  logic             inval_pend;

  logic [IDX_W-1:0] enc_idx;
  logic [TAG_W-1:0] enc_tag;
  logic [ECC_W-1:0] enc_ecc;
  logic [ECC_W-1:0] wr_ecc;

  // An invalidate pulse seen in IDLE is serviced this very cycle; it also
  // blocks a same-cycle push so the request on the bus is not accepted.
  assign inval_pend = inval_req && (state == IDLE);

  // ready_en keeps wr_ready low during reset and for the release edge.
  assign wr_if.wr_ready = ready_en && !fifo_full && (state == IDLE) && !inval_pend;
  assign push           = wr_if.wr_valid && wr_if.wr_ready;
  assign push_req       = '{idx: wr_if.wr_idx, tag: wr_if.wr_tag};

  // Buffered writes drain in IDLE and DRAIN; reads always win the RAM port.
  assign pop         = (state != SWEEP) && !fifo_empty && !rd_active;
  assign sweep_issue = (state == SWEEP) && !rd_active;
  assign issue       = pop || sweep_issue;

  assign enc_idx = (state == SWEEP) ? cnt       : head.idx;
  assign enc_tag = (state == SWEEP) ? INVAL_TAG : head.tag;

  assign busy = !fifo_empty || (state != IDLE) || inval_pend;

  ic_tag_wr_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_a     (rst_a),
    .push      (push),
    .push_data (push_req),
    .pop       (pop),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  ic_tag_ecc_encoder u_ecc (
    .idx (enc_idx),
    .tag (enc_tag),
    .ecc (enc_ecc)
  );

`ifdef IC_TAG_ECC_ERR_INJ_EN
  logic             inj_armed;
  logic [ECC_W-1:0] inj_mask;

  // Arming takes priority over consumption, so a re-arm always leaves the
  // newest mask pending for the next word.
  always_ff @(posedge clk or negedge rst_a) begin
    if (!rst_a) begin
      inj_armed <= 1'b0;
      inj_mask  <= '0;
    end else if (err_inj_arm) begin
      inj_armed <= 1'b1;
      inj_mask  <= err_inj_mask;
    end else if (issue) begin
      inj_armed <= 1'b0;
    end
  end

  assign wr_ecc = inj_armed ? (enc_ecc ^ inj_mask) : enc_ecc;
`else
  logic unused_inj;

  assign unused_inj = err_inj_arm ^ (^err_inj_mask);
  assign wr_ecc     = enc_ecc;
`endif

  always_ff @(posedge clk or negedge rst_a) begin
    if (!rst_a) begin
      state      <= IDLE;
      cnt        <= '0;
      ready_en   <= 1'b0;
      inval_done <= 1'b0;
      ram_we     <= 1'b0;
      ram_addr   <= '0;
      ram_wdata  <= '0;
    end else begin
      ready_en   <= 1'b1;
      inval_done <= 1'b0;
      ram_we     <= issue;
      if (issue) begin
        ram_addr  <= enc_idx;
        ram_wdata <= {wr_ecc, enc_tag};
      end
      unique case (state)
        IDLE: begin
          if (inval_req) state <= fifo_empty ? SWEEP : DRAIN;
        end
        DRAIN: begin
          if (fifo_empty) state <= SWEEP;
        end
        SWEEP: begin
          if (sweep_issue) begin
            cnt <= cnt + 1'b1;
            if (cnt == '1) begin
              state      <= IDLE;
              inval_done <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
